// File: rtl/not_stage_pkg.sv
// Shared ALU definitions used by the NOT slice: default width, opcode and
// the result-plus-flags record carried through the datapath.
package not_stage_pkg;

  localparam int unsigned SIZE_DEFAULT = 4;
  localparam int unsigned MAX_SIZE     = 64;

  // Opcode the operand mux decodes to route work into this slice.
  localparam logic [3:0] OP_NOT = 4'h9;

  typedef struct packed {
    logic [MAX_SIZE-1:0] data;
    logic                zero;
    logic                ones;
  } not_result_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready pipe: a main output register plus one skid register,
// with a registered ready that never depends combinationally on out_ready.
module skid_buffer
  import not_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             skid_full_reg, skid_full_next;
  logic [WIDTH-1:0] skid_data_reg, skid_data_next;
  logic             accept;
  logic             load_out;

  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    skid_full_next = skid_full_reg;
    skid_data_next = skid_data_reg;
    accept         = in_valid && !skid_full_reg;
    load_out       = !out_valid_reg || out_ready;

    if (load_out) begin
      // A full skid always drains first; in_ready was low so nothing arrives.
      if (skid_full_reg) begin
        out_data_next  = skid_data_reg;
        out_valid_next = 1'b1;
        skid_full_next = 1'b0;
      end else if (accept) begin
        out_data_next  = in_data;
        out_valid_next = 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (accept) begin
      skid_data_next = in_data;
      skid_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      skid_full_reg <= 1'b0;
      skid_data_reg <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      skid_full_reg <= skid_full_next;
      skid_data_reg <= skid_data_next;
    end
  end

  assign in_ready  = !skid_full_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: rtl/not_stage.sv
// Registered bitwise-NOT slice with zero/all-ones flags, fed through a
// two-entry skid buffer for full throughput under back-pressure.
module not_stage
  import not_stage_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] q,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] q_not,
  output logic            res_zero,
  output logic            res_ones
);

  logic            rst_meta_reg;
  logic            run_reg;
  logic [SIZE-1:0] inv;
  logic            inv_zero;
  logic            inv_ones;
  logic [SIZE+1:0] pipe_in;
  logic [SIZE+1:0] pipe_out;
  logic            pipe_valid;
  logic            skid_ready;

  // Reset asserts immediately; release waits two edges so the pipe never
  // sees a partially released reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_reg <= 1'b0;
      run_reg      <= 1'b0;
    end else begin
      rst_meta_reg <= 1'b1;
      run_reg      <= rst_meta_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_inv
      assign inv[gi] = ~q[gi];
    end
  endgenerate

  // Flags are computed before storage so they stay locked to their result.
  assign inv_zero = ~|inv;
  assign inv_ones = &inv;
  assign pipe_in  = {inv_ones, inv_zero, inv};

  skid_buffer #(
    .WIDTH(SIZE + 2)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid && run_reg),
    .in_ready (skid_ready),
    .in_data  (pipe_in),
    .out_valid(pipe_valid),
    .out_ready(out_ready),
    .out_data (pipe_out)
  );

  assign in_ready  = skid_ready && run_reg;
  assign out_valid = pipe_valid;
  assign q_not     = pipe_out[SIZE-1:0];
  assign res_zero  = pipe_valid && pipe_out[SIZE];
  assign res_ones  = pipe_valid && pipe_out[SIZE+1];

endmodule

// File: tb/tb_not_stage.sv
// Scoreboard bench for not_stage at widths 4, 8 and 1: stimulus pushes the
// expected result, per-instance monitors pop and compare on each output.
module tb_not_stage;
  import not_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready, res_zero, res_ones;
  logic [3:0] q, q_not;

  logic       in_valid8, in_ready8, out_valid8, res_zero8, res_ones8;
  logic [7:0] q8, q_not8;
  logic       in_valid1, in_ready1, out_valid1, res_zero1, res_ones1;
  logic [0:0] q1, q_not1;
  logic       always_ready = 1'b1;

  not_stage #(.SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .q(q),
    .out_valid(out_valid), .out_ready(out_ready), .q_not(q_not),
    .res_zero(res_zero), .res_ones(res_ones));

  not_stage #(.SIZE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .q(q8),
    .out_valid(out_valid8), .out_ready(always_ready), .q_not(q_not8),
    .res_zero(res_zero8), .res_ones(res_ones8));

  not_stage #(.SIZE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .q(q1),
    .out_valid(out_valid1), .out_ready(always_ready), .q_not(q_not1),
    .res_zero(res_zero1), .res_ones(res_ones1));

  int checks = 0;
  int errors = 0;

  not_result_t exp_q4[$];
  not_result_t exp_q8[$];
  not_result_t exp_q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: complement is all-ones minus operand; flags from the operand.
  function automatic not_result_t ref_not(input int unsigned width, input longint unsigned operand);
    not_result_t     r;
    longint unsigned all_ones;
    all_ones = (width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
    r.data   = all_ones - operand;
    r.zero   = (operand == all_ones);
    r.ones   = (operand == 0);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 4-bit instance, including hold-stability under back-pressure.
  logic       held = 1'b0;
  logic [3:0] held_q;
  logic [1:0] held_flags;
  always @(negedge clk) begin
    not_result_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (out_valid) begin
        if (held) begin
          chk("hold_q_not", 64'(q_not), 64'(held_q));
          chk("hold_flags", 64'({res_zero, res_ones}), 64'(held_flags));
        end
        if (exp_q4.size() == 0) begin
          chk("unexpected_out4", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q4[0];
          chk("q_not4", 64'(q_not), 64'(e.data[3:0]));
          chk("res_zero4", 64'(res_zero), 64'(e.zero));
          chk("res_ones4", 64'(res_ones), 64'(e.ones));
          if (out_ready) void'(exp_q4.pop_front());
        end
        held       = !out_ready;
        held_q     = q_not;
        held_flags = {res_zero, res_ones};
      end else begin
        held = 1'b0;
        chk("idle_flags4", 64'({res_zero, res_ones}), 64'd0);
      end
      if (in_valid && in_ready) exp_q4.push_back(ref_not(4, 64'(q)));
    end
  end

  always @(negedge clk) begin
    not_result_t e;
    if (rst_n) begin
      if (out_valid8) begin
        if (exp_q8.size() == 0) chk("unexpected_out8", 64'(out_valid8), 64'd0);
        else begin
          e = exp_q8.pop_front();
          chk("q_not8", 64'(q_not8), 64'(e.data[7:0]));
          chk("flags8", 64'({res_zero8, res_ones8}), 64'({e.zero, e.ones}));
        end
      end
      if (in_valid8 && in_ready8) exp_q8.push_back(ref_not(8, 64'(q8)));
    end
  end

  always @(negedge clk) begin
    not_result_t e;
    if (rst_n) begin
      if (out_valid1) begin
        if (exp_q1.size() == 0) chk("unexpected_out1", 64'(out_valid1), 64'd0);
        else begin
          e = exp_q1.pop_front();
          chk("q_not1", 64'(q_not1), 64'(e.data[0:0]));
          chk("flags1", 64'({res_zero1, res_ones1}), 64'({e.zero, e.ones}));
        end
      end
      if (in_valid1 && in_ready1) exp_q1.push_back(ref_not(1, 64'(q1)));
    end
  end

  task automatic wait_ready(input string name);
    for (int k = 0; k < 8 && !(in_ready && in_ready8 && in_ready1); k++) step();
    chk(name, 64'({in_ready, in_ready8, in_ready1}), 64'h7);
  endtask

  task automatic drain(input string name);
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
    in_valid1 = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (exp_q4.size() + exp_q8.size() + exp_q1.size()) != 0; k++) step();
    step();
    chk(name, 64'(exp_q4.size() + exp_q8.size() + exp_q1.size()), 64'd0);
  endtask

  initial begin
    logic [7:0] vec8 [5];
    rst_n = 1'b0;
    in_valid = 1'b0; q = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; q8 = '0;
    in_valid1 = 1'b0; q1 = '0;
    #2;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_q_not", 64'(q_not), 64'd0);
    chk("reset_flags", 64'({res_zero, res_ones}), 64'd0);
    #10 rst_n = 1'b1;
    step();
    wait_ready("in_ready_after_reset");

    // Stream 0..15 with the consumer always ready: no bubbles expected.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      q = 4'(i);
      step();
      chk("stream_valid", 64'(out_valid), 64'd1);
    end
    drain("drain_stream");

    // Back-pressure: 5 held as A, 3 parked in skid, then both released in order.
    out_ready = 1'b0;
    in_valid = 1'b1; q = 4'h5; step();
    q = 4'h3; step();
    in_valid = 1'b0; q = 4'hF; step();
    chk("bp_q_not", 64'(q_not), 64'hA);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    step();
    out_ready = 1'b1; step();
    chk("bp_second", 64'(q_not), 64'hC);
    drain("drain_bp");

    // Widths 8 and 1 with directed boundary operands.
    vec8[0] = 8'h00; vec8[1] = 8'hFF; vec8[2] = 8'hA5;
    vec8[3] = 8'($urandom); vec8[4] = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      in_valid8 = 1'b1; q8 = vec8[i];
      in_valid1 = (i < 4); q1 = 1'(i);
      step();
    end
    drain("drain_small");

    // Random traffic: toggling consumer first, then random consumer.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      q         = 4'($urandom);
      out_ready = (i < 100) ? ((i % 2) == 0) : ($urandom_range(0, 1) == 1);
      step();
    end
    drain("drain_random");

    // Asynchronous reset mid-cycle with the skid full.
    out_ready = 1'b0;
    in_valid = 1'b1; q = 4'($urandom); step();
    q = 4'($urandom); step();
    in_valid = 1'b0;
    chk("skid_full_ready", 64'(in_ready), 64'd0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_q_not", 64'(q_not), 64'd0);
    chk("async_flags", 64'({res_zero, res_ones}), 64'd0);
    exp_q4.delete();
    step();
    #3 rst_n = 1'b1;
    step();
    wait_ready("in_ready_after_async");

    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; q = 4'($urandom); step();
    end
    drain("drain_recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
